// File: rtl/qspi_pkg.sv
// Shared constants, FSM state type and helpers for the QSPI execute-in-place reader.
package qspi_pkg;

   localparam logic [7:0] QSPI_CMD_QOFR = 8'h6B;
   localparam logic [3:0] IO_DIR_SPI    = 4'b1101;
   localparam logic [3:0] IO_DIR_QIN    = 4'b0000;
   localparam logic [7:0] DQ_IDLE       = 8'hF0;
   localparam logic [1:0] RRESP_OKAY    = 2'b00;
   localparam logic [1:0] RRESP_SLVERR  = 2'b10;
   localparam logic [1:0] SCLK_ON       = 2'b10;
   localparam logic [1:0] SCLK_OFF      = 2'b00;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DUMMY,
      ST_DATA,
      ST_DRAIN,
      ST_RESP,
      ST_GAP
   } state_t;

   // Flash bytes arrive in ascending address order; the bus wants them little-endian.
   function automatic logic [31:0] bswap32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/qspi_phy_shifter.sv
// Command/address serialiser on D0 and quad-nibble packer aligned to the input pipeline latency.
module qspi_phy_shifter
   import qspi_pkg::*;
#(
   parameter int IN_LATENCY = 1
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_load,
   input  logic [39:0] i_load_word,
   input  logic        i_shift,
   output logic        o_d0,
   input  logic        i_data_sclk,
   input  logic [7:0]  i_dq_in,
   output logic [31:0] o_word
);

   logic [39:0]          r_sr;
   logic [IN_LATENCY:1]  r_vld_pipe;
   logic [31:0]          r_nibs;
   logic [3:0]           w_nib;
   logic [31:0]          w_nibs_nxt;
   logic                 w_cap;
   logic                 w_unused_dq;

   assign w_nib       = {i_dq_in[7], i_dq_in[5], i_dq_in[3], i_dq_in[1]};
   assign w_unused_dq = ^{i_dq_in[6], i_dq_in[4], i_dq_in[2], i_dq_in[0]};
   assign w_cap       = r_vld_pipe[IN_LATENCY];
   assign w_nibs_nxt  = {r_nibs[27:0], w_nib};
   assign o_d0        = r_sr[39];
   // Combinational view so the word is usable in the same cycle the last nibble lands.
   assign o_word      = bswap32(w_nibs_nxt);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sr       <= '0;
         r_vld_pipe <= '0;
         r_nibs     <= '0;
      end else begin
         if (i_load)
            r_sr <= i_load_word;
         else if (i_shift)
            r_sr <= {r_sr[38:0], 1'b0};
         r_vld_pipe[1] <= i_data_sclk;
         for (int k = 2; k <= IN_LATENCY; k++)
            r_vld_pipe[k] <= r_vld_pipe[k-1];
         if (w_cap)
            r_nibs <= w_nibs_nxt;
      end
   end

endmodule

// File: rtl/qspi_xip_reader.sv
// AXI4-Lite read port turning each word read into one Quad Output Fast Read (0x6B) on QSPI flash.
module qspi_xip_reader
   import qspi_pkg::*;
#(
   parameter int ADDR_BITS      = 24,
   parameter int DUMMY_CYCLES   = 8,
   parameter int IN_LATENCY     = 1,
   parameter int CS_HIGH_CYCLES = 2
) (
   input  logic        CLK,
   input  logic        RSTb,
   output logic [1:0]  qspi_sclk_ddr,
   output logic        qspi_CSb,
   output logic [7:0]  qspi_dq_out,
   input  logic [7:0]  qspi_dq_in,
   output logic [3:0]  qspi_io_dir,
   input  logic        mem_axi_arvalid,
   output logic        mem_axi_arready,
   input  logic [31:0] mem_axi_araddr,
   output logic        mem_axi_rvalid,
   input  logic        mem_axi_rready,
   output logic [31:0] mem_axi_rdata,
   output logic [1:0]  mem_axi_rresp
);

   localparam logic [31:0] HI_MASK = (ADDR_BITS >= 32) ? 32'h0 : ~((32'h1 << ADDR_BITS) - 32'h1);

   state_t      r_state, w_next;
   logic [5:0]  r_cnt, w_len;
   logic        w_last, w_hs, w_oor, w_d0;
   logic [31:0] w_addr_wire, w_word;
   logic [39:0] w_load_word;
   logic [31:0] r_rdata;
   logic [1:0]  r_rresp;

   assign w_oor       = |(mem_axi_araddr & HI_MASK);
   assign w_hs        = (r_state == ST_IDLE) && mem_axi_arvalid;
   assign w_addr_wire = mem_axi_araddr & ~HI_MASK & 32'hFFFF_FFFC;
   // Left-justify the address so the serialiser always starts from bit 39.
   assign w_load_word = {QSPI_CMD_QOFR, w_addr_wire << (32 - ADDR_BITS)};

   qspi_phy_shifter #(.IN_LATENCY(IN_LATENCY)) u_phy (
      .i_clk       (CLK),
      .i_rst_n     (RSTb),
      .i_load      (w_hs && !w_oor),
      .i_load_word (w_load_word),
      .i_shift     ((r_state == ST_CMD) || (r_state == ST_ADDR)),
      .o_d0        (w_d0),
      .i_data_sclk (r_state == ST_DATA),
      .i_dq_in     (qspi_dq_in),
      .o_word      (w_word)
   );

   // Reset lands in GAP so arready stays low until the CS-high gap has elapsed.
   always_ff @(posedge CLK or negedge RSTb) begin
      if (!RSTb) begin
         r_state <= ST_GAP;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= (w_next != r_state) ? 6'd0 : r_cnt + 6'd1;
      end
   end

   always_comb begin
      case (r_state)
         ST_CMD, ST_DATA: w_len = 6'd8;
         ST_ADDR:         w_len = 6'(ADDR_BITS);
         ST_DUMMY:        w_len = 6'(DUMMY_CYCLES);
         ST_DRAIN:        w_len = 6'(IN_LATENCY);
         ST_GAP:          w_len = 6'(CS_HIGH_CYCLES);
         default:         w_len = 6'd1;
      endcase
   end

   assign w_last = (r_cnt == w_len - 6'd1);

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (mem_axi_arvalid) w_next = w_oor ? ST_RESP : ST_CMD;
         ST_CMD:   if (w_last) w_next = ST_ADDR;
         ST_ADDR:  if (w_last) w_next = (DUMMY_CYCLES == 0) ? ST_DATA : ST_DUMMY;
         ST_DUMMY: if (w_last) w_next = ST_DATA;
         ST_DATA:  if (w_last) w_next = ST_DRAIN;
         ST_DRAIN: if (w_last) w_next = ST_RESP;
         ST_RESP:  if (mem_axi_rready) w_next = ST_GAP;
         ST_GAP:   if (w_last) w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      qspi_CSb        = 1'b1;
      qspi_sclk_ddr   = SCLK_OFF;
      qspi_io_dir     = IO_DIR_SPI;
      qspi_dq_out     = DQ_IDLE;
      mem_axi_arready = 1'b0;
      mem_axi_rvalid  = 1'b0;
      case (r_state)
         ST_IDLE: mem_axi_arready = 1'b1;
         ST_CMD, ST_ADDR: begin
            qspi_CSb      = 1'b0;
            qspi_sclk_ddr = SCLK_ON;
            qspi_dq_out   = {DQ_IDLE[7:2], w_d0, w_d0};
         end
         ST_DUMMY, ST_DATA: begin
            qspi_CSb      = 1'b0;
            qspi_sclk_ddr = SCLK_ON;
            qspi_io_dir   = IO_DIR_QIN;
         end
         ST_RESP: mem_axi_rvalid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTb) begin
      if (!RSTb) begin
         r_rdata <= '0;
         r_rresp <= RRESP_OKAY;
      end else if (w_hs && w_oor) begin
         r_rdata <= '0;
         r_rresp <= RRESP_SLVERR;
      end else if ((r_state == ST_DRAIN) && w_last) begin
         r_rdata <= w_word;
         r_rresp <= RRESP_OKAY;
      end
   end

   assign mem_axi_rdata = r_rdata;
   assign mem_axi_rresp = r_rresp;

endmodule

// File: tb/tb_qspi_xip_reader.sv
// Bench for qspi_xip_reader: two configurations driven against a small behavioural QSPI flash.
module tb_qspi_xip_reader;

   localparam int AB0 = 24, DC0 = 8, IL0 = 1;
   localparam int AB1 = 32, DC1 = 0, IL1 = 2;

   logic        CLK  = 1'b0;
   logic        RSTb = 1'b0;
   logic [1:0]  sclk[2];
   logic        csb[2];
   logic [7:0]  dqo[2];
   logic [7:0]  dqi[2];
   logic [3:0]  iodir[2];
   logic        arvalid[2], arready[2], rvalid[2], rready[2];
   logic [31:0] araddr[2], rdata[2];
   logic [1:0]  rresp[2];

   int n_cmp = 0, n_err = 0;

   always #5 CLK = ~CLK;

   qspi_xip_reader #(.ADDR_BITS(AB0), .DUMMY_CYCLES(DC0), .IN_LATENCY(IL0), .CS_HIGH_CYCLES(2)) u_dut0 (
      .CLK(CLK), .RSTb(RSTb), .qspi_sclk_ddr(sclk[0]), .qspi_CSb(csb[0]), .qspi_dq_out(dqo[0]),
      .qspi_dq_in(dqi[0]), .qspi_io_dir(iodir[0]), .mem_axi_arvalid(arvalid[0]),
      .mem_axi_arready(arready[0]), .mem_axi_araddr(araddr[0]), .mem_axi_rvalid(rvalid[0]),
      .mem_axi_rready(rready[0]), .mem_axi_rdata(rdata[0]), .mem_axi_rresp(rresp[0]));

   qspi_xip_reader #(.ADDR_BITS(AB1), .DUMMY_CYCLES(DC1), .IN_LATENCY(IL1), .CS_HIGH_CYCLES(2)) u_dut1 (
      .CLK(CLK), .RSTb(RSTb), .qspi_sclk_ddr(sclk[1]), .qspi_CSb(csb[1]), .qspi_dq_out(dqo[1]),
      .qspi_dq_in(dqi[1]), .qspi_io_dir(iodir[1]), .mem_axi_arvalid(arvalid[1]),
      .mem_axi_arready(arready[1]), .mem_axi_araddr(araddr[1]), .mem_axi_rvalid(rvalid[1]),
      .mem_axi_rready(rready[1]), .mem_axi_rdata(rdata[1]), .mem_axi_rresp(rresp[1]));

   function automatic int ab(input int i);
      return (i == 0) ? AB0 : AB1;
   endfunction

   function automatic int dc(input int i);
      return (i == 0) ? DC0 : DC1;
   endfunction

   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      case (a)
         32'h100: return 8'h11;
         32'h101: return 8'h22;
         32'h102: return 8'h33;
         32'h103: return 8'h44;
         32'h200: return 8'hA1;
         32'h201: return 8'hB2;
         32'h202: return 8'hC3;
         32'h203: return 8'hD4;
         default: return a[7:0] ^ 8'h5A;
      endcase
   endfunction

   function automatic logic [7:0] spread(input logic [3:0] n);
      return {n[3], n[3], n[2], n[2], n[1], n[1], n[0], n[0]};
   endfunction

   // Flash model: decodes command/address from D0, returns quad nibbles delayed by IN_LATENCY.
   int          cnt[2]      = '{0, 0};
   int          nsclk[2]    = '{0, 0};
   int          nfall[2]    = '{0, 0};
   int          nbad[2]     = '{0, 0};
   int          hi_run[2]   = '{0, 0};
   int          last_gap[2] = '{0, 0};
   logic [7:0]  cmd_sh[2]   = '{8'h0, 8'h0};
   logic [31:0] adr_sh[2]   = '{32'h0, 32'h0};
   logic [3:0]  np1[2]      = '{4'h0, 4'h0};
   logic [3:0]  np2[2]      = '{4'h0, 4'h0};
   logic [3:0]  m_nib;
   logic [7:0]  m_byte;
   int          m_d;

   always @(posedge CLK) begin
      for (int i = 0; i < 2; i++) begin
         m_nib = 4'h0;
         if (csb[i] !== 1'b0) begin
            cnt[i] = 0;
            hi_run[i] = hi_run[i] + 1;
            if (sclk[i] !== 2'b00 || iodir[i] !== 4'b1101) nbad[i] = nbad[i] + 1;
         end else begin
            if (hi_run[i] > 0) begin
               last_gap[i] = hi_run[i];
               nfall[i] = nfall[i] + 1;
               cmd_sh[i] = 8'h0;
               adr_sh[i] = 32'h0;
            end
            hi_run[i] = 0;
            if (sclk[i] !== 2'b10) begin
               nbad[i] = nbad[i] + 1;
            end else begin
               if (cnt[i] < 8 + ab(i)) begin
                  if (iodir[i] !== 4'b1101 || dqo[i][1] !== dqo[i][0]) nbad[i] = nbad[i] + 1;
                  if (cnt[i] < 8) cmd_sh[i] = {cmd_sh[i][6:0], dqo[i][0]};
                  else            adr_sh[i] = {adr_sh[i][30:0], dqo[i][0]};
               end else begin
                  if (iodir[i] !== 4'b0000) nbad[i] = nbad[i] + 1;
                  m_d = cnt[i] - (8 + ab(i) + dc(i));
                  if (m_d >= 8) nbad[i] = nbad[i] + 1;
                  else if (m_d >= 0) begin
                     m_byte = mem_byte(adr_sh[i] + 32'(m_d / 2));
                     m_nib = m_d[0] ? m_byte[3:0] : m_byte[7:4];
                  end
               end
               cnt[i] = cnt[i] + 1;
               nsclk[i] = nsclk[i] + 1;
            end
         end
         np2[i] <= np1[i];
         np1[i] <= m_nib;
      end
   end

   assign dqi[0] = spread(np1[0]);
   assign dqi[1] = spread(np2[1]);

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Handshake cycle is N; lat is the offset of the first cycle showing rvalid.
   task automatic do_read(input int i, input logic [31:0] a,
                          output logic [31:0] data, output logic [1:0] resp, output int lat);
      int k;
      lat = -1; data = '0; resp = '0;
      @(negedge CLK);
      araddr[i] = a; arvalid[i] = 1'b1; rready[i] = 1'b1;
      k = 0;
      while (arready[i] !== 1'b1 && k < 100) begin
         @(negedge CLK);
         k++;
      end
      if (arready[i] !== 1'b1) begin
         arvalid[i] = 1'b0;
         return;
      end
      for (k = 1; k <= 200; k++) begin
         @(negedge CLK);
         arvalid[i] = 1'b0;
         if (rvalid[i] === 1'b1) begin
            lat = k; data = rdata[i]; resp = rresp[i];
            break;
         end
      end
      @(negedge CLK);
      rready[i] = 1'b0;
   endtask

   typedef struct {
      int          inst;
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  resp;
      int          lat;
      int          nsclk;
      logic [31:0] wire_addr;
   } vec_t;

   vec_t vt[8];

   initial begin
      logic [31:0] d;
      logic [1:0]  r;
      int          lat, s0, f0, b0, seen, k;

      vt[0] = '{0, 32'h0000_0100, 32'h4433_2211, 2'b00, 50, 48, 32'h0000_0100};
      vt[1] = '{0, 32'h0000_0103, 32'h4433_2211, 2'b00, 50, 48, 32'h0000_0100};
      vt[2] = '{0, 32'h0100_0000, 32'h0000_0000, 2'b10,  1,  0, 32'h0};
      vt[3] = '{1, 32'h0000_0200, 32'hD4C3_B2A1, 2'b00, 51, 48, 32'h0000_0200};
      vt[4] = '{1, 32'hFFFF_FFFC, 32'hA5A4_A7A6, 2'b00, 51, 48, 32'hFFFF_FFFC};
      vt[5] = '{0, 32'h00FF_FFFF, 32'hA5A4_A7A6, 2'b00, 50, 48, 32'h00FF_FFFC};
      vt[6] = '{0, 32'h8000_0200, 32'h0000_0000, 2'b10,  1,  0, 32'h0};
      vt[7] = '{1, 32'h0000_0202, 32'hD4C3_B2A1, 2'b00, 51, 48, 32'h0000_0200};

      for (int i = 0; i < 2; i++) begin
         arvalid[i] = 1'b0; rready[i] = 1'b0; araddr[i] = 32'h0;
      end

      @(negedge CLK);
      for (int i = 0; i < 2; i++)
         chk($sformatf("reset_state%0d", i),
             {csb[i], sclk[i], iodir[i], dqo[i], arready[i], rvalid[i], rdata[i], rresp[i]},
             {1'b1, 2'b00, 4'b1101, 8'hF0, 1'b0, 1'b0, 32'h0, 2'b00});
      @(negedge CLK);
      RSTb = 1'b1;

      for (int j = 0; j < 8; j++) begin
         int i;
         i = vt[j].inst;
         s0 = nsclk[i]; f0 = nfall[i]; b0 = nbad[i];
         do_read(i, vt[j].addr, d, r, lat);
         chk($sformatf("v%0d_latency", j), lat, vt[j].lat);
         chk($sformatf("v%0d_rdata", j), d, vt[j].data);
         chk($sformatf("v%0d_rresp", j), r, vt[j].resp);
         chk($sformatf("v%0d_sclk_cycles", j), nsclk[i] - s0, vt[j].nsclk);
         chk($sformatf("v%0d_cs_falls", j), nfall[i] - f0, (vt[j].nsclk > 0) ? 1 : 0);
         chk($sformatf("v%0d_pin_errors", j), nbad[i] - b0, 0);
         chk($sformatf("v%0d_rvalid_drop", j), rvalid[i], 1'b0);
         if (vt[j].nsclk > 0) begin
            chk($sformatf("v%0d_cmd", j), cmd_sh[i], 8'h6B);
            chk($sformatf("v%0d_wire_addr", j), adr_sh[i], vt[j].wire_addr);
         end
      end

      // Back-pressure: rready low for 10 cycles while a second request is already pending.
      @(negedge CLK);
      araddr[0] = 32'h100; arvalid[0] = 1'b1; rready[0] = 1'b0;
      k = 0;
      while (arready[0] !== 1'b1 && k < 100) begin @(negedge CLK); k++; end
      @(negedge CLK);
      k = 0;
      while (rvalid[0] !== 1'b1 && k < 200) begin @(negedge CLK); k++; end
      chk("hold_rvalid_seen", rvalid[0], 1'b1);
      for (int c = 0; c < 10; c++) begin
         chk($sformatf("hold_c%0d", c), {rvalid[0], arready[0], rdata[0], rresp[0]},
             {1'b1, 1'b0, 32'h4433_2211, 2'b00});
         @(negedge CLK);
      end
      rready[0] = 1'b1;
      @(negedge CLK);
      chk("hold_rvalid_drop", rvalid[0], 1'b0);
      k = 0;
      while (rvalid[0] !== 1'b1 && k < 200) begin @(negedge CLK); k++; end
      chk("pending_read_data", {rvalid[0], rdata[0]}, {1'b1, 32'h4433_2211});
      chk("cs_gap_ge2", (last_gap[0] >= 2), 1'b1);
      arvalid[0] = 1'b0;
      @(negedge CLK);
      rready[0] = 1'b0;
      @(negedge CLK);

      // Reset pulse in the middle of the dummy phase.
      araddr[0] = 32'h100; arvalid[0] = 1'b1; rready[0] = 1'b1;
      k = 0;
      while (arready[0] !== 1'b1 && k < 100) begin @(negedge CLK); k++; end
      for (int c = 1; c <= 36; c++) begin
         @(negedge CLK);
         arvalid[0] = 1'b0;
      end
      chk("in_dummy", {csb[0], iodir[0]}, {1'b0, 4'b0000});
      RSTb = 1'b0;
      #1;
      chk("abort_outputs", {csb[0], iodir[0], rvalid[0], sclk[0], arready[0], dqo[0]},
          {1'b1, 4'b1101, 1'b0, 2'b00, 1'b0, 8'hF0});
      @(negedge CLK);
      RSTb = 1'b1;
      seen = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge CLK);
         if (rvalid[0] === 1'b1) seen++;
      end
      chk("no_rvalid_after_abort", seen, 0);
      do_read(0, 32'h100, d, r, lat);
      chk("post_abort_rdata", d, 32'h4433_2211);
      chk("post_abort_latency", lat, 50);
      rready[0] = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/qspi_xip_reader.md
Name: qspi_xip_reader

Overview:
Parametrised, memory-mapped execute-in-place read engine for external QSPI NOR flash. Each AXI4-Lite read becomes one Quad Output Fast Read (0x6B) transaction returning one 32-bit word. Sits between the instruction/data cache arbiter and the DDR IO cells on the QSPI pins. Successor to the register-only flash controller.

Parameters:
ADDR_BITS, 24, flash address width sent on the wire; legal values 24 or 32.
DUMMY_CYCLES, 8, SCLK cycles between address and data; range 0-15.
IN_LATENCY, 1, CLK cycles from an SCLK rising edge until the sample appears on qspi_dq_in; range 1-3.
CS_HIGH_CYCLES, 2, minimum CLK cycles CSb stays high between transactions; range 1-15.

Ports:
CLK  in  1  system clock
RSTb  in  1  asynchronous active-low reset
qspi_sclk_ddr  out  2  SCLK DDR pair; [0] is the first half-cycle, [1] the second half
qspi_CSb  out  1  flash chip select, active low
qspi_dq_out  out  8  lane i uses bits [2i+1:2i], same half-cycle order as SCLK
qspi_dq_in  in  8  lane i uses bits [2i+1:2i]; bit [2i+1] is the value sampled at the SCLK rising edge
qspi_io_dir  out  4  per-lane direction, 1 = drive
mem_axi_arvalid  in  1  read address valid
mem_axi_arready  out  1  read address ready
mem_axi_araddr  in  32  byte address
mem_axi_rvalid  out  1  read data valid
mem_axi_rready  in  1  read data accept
mem_axi_rdata  out  32  read data
mem_axi_rresp  out  2  2'b00 OKAY, 2'b10 SLVERR

Behaviour:
- Clock and reset: one clock, CLK. Reset RSTb is asynchronous and active-low.
- Reset values: CSb=1, sclk_ddr=2'b00, io_dir=4'b1101, dq_out=8'hF0 (D2/D3 driven high as WP#/HOLD#), arready=0, rvalid=0, rdata=0, rresp=0.
- Reset mid-transaction: all outputs return to reset values immediately. No rvalid is produced for the aborted read.
- FSM states:
  - IDLE: arready=1 only when the CS-high gap is satisfied and rvalid=0. A handshake in cycle N moves to CMD in N+1.
  - CMD: 8 SCLK cycles.
  - ADDR: ADDR_BITS SCLK cycles.
  - DUMMY: DUMMY_CYCLES SCLK cycles; skipped when DUMMY_CYCLES=0.
  - DATA: 8 SCLK cycles.
  - DRAIN: IN_LATENCY cycles.
  - RESP: hold until rready.
  - GAP: CS_HIGH_CYCLES cycles, then IDLE.
- Active SCLK cycle: sclk_ddr=2'b10 (rising edge mid-cycle). When not active, sclk_ddr=2'b00.
- CMD and ADDR phases: D0 only, MSB first, both DDR bits equal. io_dir=4'b1101.
- Address on the wire: {araddr[ADDR_BITS-1:2],2'b00}. araddr[1:0] is ignored (word-aligned reads only).
- DUMMY and DATA phases: io_dir=4'b0000.
- Data capture: each captured nibble is {dq_in[7],dq_in[5],dq_in[3],dq_in[1]}, taken IN_LATENCY cycles after its SCLK cycle. Nibbles arrive high nibble first per byte, bytes in ascending address order.
- Packing: byte at addr goes to rdata[7:0], addr+3 to rdata[31:24] (little-endian).
- CSb timing: falls in cycle N+1 and rises in the cycle after the last DATA SCLK.
- Latency: rvalid asserts in cycle N + 1 + 8 + ADDR_BITS + DUMMY_CYCLES + 8 + IN_LATENCY. With defaults this is N+50.
- Response hold: rvalid, rdata and rresp are held stable until rready. The cycle after rvalid&&rready, rvalid drops and the FSM enters GAP.
- One outstanding read only. arready stays 0 from the handshake until GAP completes.
- Out of range: if ADDR_BITS<32 and araddr[31:ADDR_BITS]!=0, no flash transaction is started and CSb stays high. rvalid asserts in N+1 with rdata=0 and rresp=2'b10.
- Simultaneous events: arvalid arriving during RESP or GAP waits; it is not dropped. rready already high when rvalid rises completes in that same cycle.

Decomposition:
- Package qspi_pkg:
  - opcode constant QSPI_CMD_QOFR=8'h6B
  - state enum
  - io_dir constants IO_DIR_SPI=4'b1101 and IO_DIR_QIN=4'b0000
  - idle dq value 8'hF0
  - rresp constants
- One sub-module, qspi_phy_shifter: MSB-first serial shift-out on D0 plus nibble-to-word packer with IN_LATENCY delay alignment. The FSM stays in qspi_xip_reader.

Test Plan:
- Flash model holds bytes 11 22 33 44 at 0x000100. Read araddr=0x00000100 with defaults -> D0 shows 0x6B then 0x000100 MSB first; rvalid in N+50; rdata=0x44332211, rresp=00.
- araddr=0x00000103 -> wire address 0x000100; rdata=0x44332211.
- araddr=0x01000000 with ADDR_BITS=24 -> CSb never falls; rvalid in N+1; rdata=0, rresp=10.
- Hold rready=0 for 10 cycles with arvalid held high -> rdata stable, arready=0 throughout; next CSb fall is at least 2 cycles after the previous CSb rise.
- ADDR_BITS=32, DUMMY_CYCLES=0, IN_LATENCY=2, read 0x00000200 -> 32 address bits on D0; rvalid in N+51.
- Pulse RSTb low during DUMMY -> CSb=1, io_dir=1101, rvalid=0 immediately. A new read afterwards returns correct data.
